// File: rtl/tx_page_sched.sv
// tx_page_sched: write-port arbiter and send scheduler for the four-page USB TX buffer.
// Define TX_SCHED_TIMEOUT_EN to build in the writer abort timer (otherwise err_timeout is tied low).
module tx_page_sched #(
    parameter int TIMEOUT_CYC       = 1024,
    parameter int OVF_NBIT          = 8,
    parameter int BUFFER_BADDR_NBIT = 2
) (
    input  logic                         mclk,
    input  logic                         rst_n,
    input  logic [1:0]                   wr_req,
    input  logic [1:0]                   wr_eop,
    output logic [1:0]                   wr_gnt,
    output logic [BUFFER_BADDR_NBIT-1:0] wr_baddr,
    input  logic                         acq_start,
    output logic                         usb_req,
    output logic [BUFFER_BADDR_NBIT-1:0] usb_baddr,
    input  logic                         usb_ack,
    input  logic                         usb_done,
    output logic [OVF_NBIT-1:0]          ovf_cnt,
    output logic                         err_timeout
);

    typedef enum logic [1:0] {
        PG_FREE  = 2'd0,
        PG_FILL  = 2'd1,
        PG_READY = 2'd2,
        PG_SEND  = 2'd3
    } page_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_CTRL = 2'd1,
        W_DATA = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } snd_state_e;

    // Page 0 maps to address 0, data pages to 2 (ptr=0) and 3 (ptr=1).
    function automatic logic [BUFFER_BADDR_NBIT-1:0] page_addr(input logic is_data, input logic ptr);
        logic [BUFFER_BADDR_NBIT-1:0] addr;
        addr = {BUFFER_BADDR_NBIT{1'b0}};
        if (is_data) begin
            addr[1:0] = {1'b1, ptr};
        end else begin
            addr[1:0] = 2'b00;
        end
        return addr;
    endfunction

    wr_state_e   w_state_r, w_state_s;
    snd_state_e  s_state_r, s_state_s;
    page_state_e pg0_r, pg0_s;
    page_state_e pgd_r [2];
    page_state_e pgd_s [2];

    logic wr_ptr_r, wr_ptr_s, wr_ptr_eff_s;
    logic tx_ptr_r, tx_ptr_s, tx_ptr_eff_s;
    logic acq_pend_r, acq_pend_s, acq_ok_s, acq_apply_s;
    logic s_data_r, s_data_s;
    logic req1_d_r, ovf_rise_s;
    logic [OVF_NBIT-1:0] ovf_r, ovf_s;

    logic gnt_ctrl_s, gnt_data_s, fill_done_s, fill_abort_s, tmo_s;
    logic sel_ctrl_s, sel_data_s, release_s;

    logic [1:0]                   gnt_r, gnt_s;
    logic [BUFFER_BADDR_NBIT-1:0] wbaddr_r, wbaddr_s;
    logic [BUFFER_BADDR_NBIT-1:0] ubaddr_r, ubaddr_s;
    logic                         usb_req_r, usb_req_s;
    logic                         err_r;

    // A pointer restart is only safe once both data pages are idle and no data fill is open;
    // when it lands, this cycle's arbitration already uses page 2.
    assign acq_ok_s     = (pgd_r[0] == PG_FREE) && (pgd_r[1] == PG_FREE) && (w_state_r != W_DATA);
    assign acq_apply_s  = (acq_start | acq_pend_r) & acq_ok_s;
    assign wr_ptr_eff_s = acq_apply_s ? 1'b0 : wr_ptr_r;
    assign tx_ptr_eff_s = acq_apply_s ? 1'b0 : tx_ptr_r;
    assign ovf_rise_s   = wr_req[1] & ~req1_d_r & (pgd_r[wr_ptr_eff_s] != PG_FREE);

`ifdef TX_SCHED_TIMEOUT_EN
    localparam int TCNT_NBIT = $clog2(TIMEOUT_CYC + 1);
    logic [TCNT_NBIT-1:0] tcnt_r;

    assign tmo_s = (w_state_r != W_IDLE) && (tcnt_r == TCNT_NBIT'(TIMEOUT_CYC - 1));

    // Counts cycles the current grant has been held; cleared whenever the write port is idle.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r <= {TCNT_NBIT{1'b0}};
        end else if (w_state_r == W_IDLE) begin
            tcnt_r <= {TCNT_NBIT{1'b0}};
        end else begin
            tcnt_r <= tcnt_r + TCNT_NBIT'(1);
        end
    end
`else
    localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
    assign tmo_s = 1'b0;
`endif

    // Write-port FSM: control beats data; data only ever targets page wr_ptr.
    always_comb begin
        w_state_s    = w_state_r;
        gnt_ctrl_s   = 1'b0;
        gnt_data_s   = 1'b0;
        fill_done_s  = 1'b0;
        fill_abort_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (wr_req[0] && (pg0_r == PG_FREE)) begin
                    gnt_ctrl_s = 1'b1;
                    w_state_s  = W_CTRL;
                end else if (wr_req[1] && (pgd_r[wr_ptr_eff_s] == PG_FREE)) begin
                    gnt_data_s = 1'b1;
                    w_state_s  = W_DATA;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_CTRL: begin
                if (wr_eop[0]) begin
                    fill_done_s = 1'b1;
                    w_state_s   = W_IDLE;
                end else if (tmo_s) begin
                    fill_abort_s = 1'b1;
                    w_state_s    = W_IDLE;
                end else begin
                    w_state_s = W_CTRL;
                end
            end
            W_DATA: begin
                if (wr_eop[1]) begin
                    fill_done_s = 1'b1;
                    w_state_s   = W_IDLE;
                end else if (tmo_s) begin
                    fill_abort_s = 1'b1;
                    w_state_s    = W_IDLE;
                end else begin
                    w_state_s = W_DATA;
                end
            end
            default: begin
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Send FSM: page 0 first, then the data page at tx_ptr.
    always_comb begin
        s_state_s  = s_state_r;
        sel_ctrl_s = 1'b0;
        sel_data_s = 1'b0;
        release_s  = 1'b0;
        case (s_state_r)
            S_IDLE: begin
                if (pg0_r == PG_READY) begin
                    sel_ctrl_s = 1'b1;
                    s_state_s  = S_REQ;
                end else if (pgd_r[tx_ptr_eff_s] == PG_READY) begin
                    sel_data_s = 1'b1;
                    s_state_s  = S_REQ;
                end else begin
                    s_state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (usb_ack) begin
                    s_state_s = S_BUSY;
                end else begin
                    s_state_s = S_REQ;
                end
            end
            S_BUSY: begin
                if (usb_done) begin
                    release_s = 1'b1;
                    s_state_s = S_IDLE;
                end else begin
                    s_state_s = S_BUSY;
                end
            end
            default: begin
                s_state_s = S_IDLE;
            end
        endcase
    end

    // Page state, pointer and bookkeeping updates; events on one page are exclusive by its state.
    always_comb begin
        pg0_s = pg0_r;
        if (gnt_ctrl_s) begin
            pg0_s = PG_FILL;
        end else if (fill_done_s && (w_state_r == W_CTRL)) begin
            pg0_s = PG_READY;
        end else if (fill_abort_s && (w_state_r == W_CTRL)) begin
            pg0_s = PG_FREE;
        end else if (sel_ctrl_s) begin
            pg0_s = PG_SEND;
        end else if (release_s && !s_data_r) begin
            pg0_s = PG_FREE;
        end else begin
            pg0_s = pg0_r;
        end

        for (int i = 0; i < 2; i++) begin
            pgd_s[i] = pgd_r[i];
            if (gnt_data_s && (wr_ptr_eff_s == 1'(i))) begin
                pgd_s[i] = PG_FILL;
            end else if (fill_done_s && (w_state_r == W_DATA) && (wr_ptr_r == 1'(i))) begin
                pgd_s[i] = PG_READY;
            end else if (fill_abort_s && (w_state_r == W_DATA) && (wr_ptr_r == 1'(i))) begin
                pgd_s[i] = PG_FREE;
            end else if (sel_data_s && (tx_ptr_eff_s == 1'(i))) begin
                pgd_s[i] = PG_SEND;
            end else if (release_s && s_data_r && (tx_ptr_r == 1'(i))) begin
                pgd_s[i] = PG_FREE;
            end else begin
                pgd_s[i] = pgd_r[i];
            end
        end

        if (fill_done_s && (w_state_r == W_DATA)) begin
            wr_ptr_s = ~wr_ptr_r;
        end else begin
            wr_ptr_s = wr_ptr_eff_s;
        end

        if (release_s && s_data_r) begin
            tx_ptr_s = ~tx_ptr_r;
        end else begin
            tx_ptr_s = tx_ptr_eff_s;
        end

        if (sel_ctrl_s) begin
            s_data_s = 1'b0;
        end else if (sel_data_s) begin
            s_data_s = 1'b1;
        end else begin
            s_data_s = s_data_r;
        end

        if (acq_apply_s) begin
            acq_pend_s = 1'b0;
        end else if (acq_start) begin
            acq_pend_s = 1'b1;
        end else begin
            acq_pend_s = acq_pend_r;
        end

        if (ovf_rise_s && (ovf_r != {OVF_NBIT{1'b1}})) begin
            ovf_s = ovf_r + OVF_NBIT'(1);
        end else begin
            ovf_s = ovf_r;
        end
    end

    // Next values of the registered outputs, derived from the next FSM states.
    always_comb begin
        gnt_s    = 2'b00;
        wbaddr_s = {BUFFER_BADDR_NBIT{1'b0}};
        case (w_state_s)
            W_CTRL: begin
                gnt_s    = 2'b01;
                wbaddr_s = page_addr(1'b0, 1'b0);
            end
            W_DATA: begin
                gnt_s    = 2'b10;
                wbaddr_s = page_addr(1'b1, wr_ptr_s);
            end
            default: begin
                gnt_s    = 2'b00;
                wbaddr_s = {BUFFER_BADDR_NBIT{1'b0}};
            end
        endcase

        usb_req_s = (s_state_s == S_REQ);
        if (s_state_s == S_REQ) begin
            ubaddr_s = page_addr(s_data_s, tx_ptr_s);
        end else begin
            ubaddr_s = {BUFFER_BADDR_NBIT{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r  <= W_IDLE;
            s_state_r  <= S_IDLE;
            pg0_r      <= PG_FREE;
            pgd_r[0]   <= PG_FREE;
            pgd_r[1]   <= PG_FREE;
            wr_ptr_r   <= 1'b0;
            tx_ptr_r   <= 1'b0;
            acq_pend_r <= 1'b0;
            s_data_r   <= 1'b0;
            req1_d_r   <= 1'b0;
            ovf_r      <= {OVF_NBIT{1'b0}};
            gnt_r      <= 2'b00;
            wbaddr_r   <= {BUFFER_BADDR_NBIT{1'b0}};
            usb_req_r  <= 1'b0;
            ubaddr_r   <= {BUFFER_BADDR_NBIT{1'b0}};
            err_r      <= 1'b0;
        end else begin
            w_state_r  <= w_state_s;
            s_state_r  <= s_state_s;
            pg0_r      <= pg0_s;
            pgd_r[0]   <= pgd_s[0];
            pgd_r[1]   <= pgd_s[1];
            wr_ptr_r   <= wr_ptr_s;
            tx_ptr_r   <= tx_ptr_s;
            acq_pend_r <= acq_pend_s;
            s_data_r   <= s_data_s;
            req1_d_r   <= wr_req[1];
            ovf_r      <= ovf_s;
            gnt_r      <= gnt_s;
            wbaddr_r   <= wbaddr_s;
            usb_req_r  <= usb_req_s;
            ubaddr_r   <= ubaddr_s;
            err_r      <= fill_abort_s;
        end
    end

    assign wr_gnt      = gnt_r;
    assign wr_baddr    = wbaddr_r;
    assign usb_req     = usb_req_r;
    assign usb_baddr   = ubaddr_r;
    assign ovf_cnt     = ovf_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_tx_page_sched.sv
// Bench for tx_page_sched: directed scenarios plus random traffic checked every cycle
// against a page-table reference model.
module tb_tx_page_sched;

    localparam int TO_CYC = 16;
    localparam int OVF_W  = 3;
    localparam int BA_W   = 2;
`ifdef TX_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int FREE = 0, FILL = 1, READY = 2, SEND = 3;

    logic            mclk = 1'b0;
    logic            rst_n;
    logic [1:0]      wr_req, wr_eop, wr_gnt;
    logic [BA_W-1:0] wr_baddr, usb_baddr;
    logic            acq_start, usb_req, usb_ack, usb_done, err_timeout;
    logic [OVF_W-1:0] ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: page table indexed by page number, writer/sender as (mode, page).
    int m_pg [4];
    int m_wmode, m_wpage, m_smode, m_spage, m_wptr, m_tptr, m_pend, m_ovf, m_prev1, m_tcnt;
    int e_gnt, e_wba, e_ureq, e_uba, e_err;

    tx_page_sched #(.TIMEOUT_CYC(TO_CYC), .OVF_NBIT(OVF_W), .BUFFER_BADDR_NBIT(BA_W)) dut (
        .mclk(mclk), .rst_n(rst_n), .wr_req(wr_req), .wr_eop(wr_eop), .wr_gnt(wr_gnt),
        .wr_baddr(wr_baddr), .acq_start(acq_start), .usb_req(usb_req), .usb_baddr(usb_baddr),
        .usb_ack(usb_ack), .usb_done(usb_done), .ovf_cnt(ovf_cnt), .err_timeout(err_timeout)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) m_pg[p] = FREE;
        m_wmode = 0; m_wpage = 0; m_smode = 0; m_spage = 0;
        m_wptr = 2; m_tptr = 2; m_pend = 0; m_ovf = 0; m_prev1 = 0; m_tcnt = 0;
        e_gnt = 0; e_wba = 0; e_ureq = 0; e_uba = 0; e_err = 0;
    endtask

    task automatic model_clock();
        int  np [4];
        int  wp, tp;
        bit  apply, eop_hit;
        np    = m_pg;
        apply = (acq_start || (m_pend != 0)) && m_pg[2] == FREE && m_pg[3] == FREE && m_wmode != 2;
        wp    = apply ? 2 : m_wptr;
        tp    = apply ? 2 : m_tptr;
        if (wr_req[1] && m_prev1 == 0 && m_pg[wp] != FREE && m_ovf < (1 << OVF_W) - 1) m_ovf++;
        m_prev1 = int'(wr_req[1]);
        m_pend  = apply ? 0 : (acq_start ? 1 : m_pend);
        e_err   = 0;
        if (m_wmode == 0) begin
            if (wr_req[0] && m_pg[0] == FREE) begin
                np[0] = FILL; m_wmode = 1; m_wpage = 0; m_tcnt = 0;
            end else if (wr_req[1] && m_pg[wp] == FREE) begin
                np[wp] = FILL; m_wmode = 2; m_wpage = wp; m_tcnt = 0;
            end
        end else begin
            eop_hit = (m_wmode == 1) ? wr_eop[0] : wr_eop[1];
            if (eop_hit) begin
                np[m_wpage] = READY;
                if (m_wmode == 2) wp = 5 - m_wpage;
                m_wmode = 0;
            end else if (TMO_EN && m_tcnt == TO_CYC - 1) begin
                np[m_wpage] = FREE; m_wmode = 0; e_err = 1;
            end else begin
                m_tcnt++;
            end
        end
        m_wptr = wp;
        if (m_smode == 0) begin
            if (m_pg[0] == READY) begin
                m_spage = 0; np[0] = SEND; m_smode = 1;
            end else if (m_pg[tp] == READY) begin
                m_spage = tp; np[tp] = SEND; m_smode = 1;
            end
        end else if (m_smode == 1) begin
            if (usb_ack) m_smode = 2;
        end else if (usb_done) begin
            np[m_spage] = FREE;
            if (m_spage != 0) tp = 5 - m_spage;
            m_smode = 0;
        end
        m_tptr = tp;
        m_pg   = np;
        e_gnt  = (m_wmode == 1) ? 1 : (m_wmode == 2) ? 2 : 0;
        e_wba  = (m_wmode == 0) ? 0 : m_wpage;
        e_ureq = (m_smode == 1) ? 1 : 0;
        e_uba  = (m_smode == 1) ? m_spage : 0;
    endtask

    task automatic check_model();
        check("wr_gnt",      32'(wr_gnt),      e_gnt);
        check("wr_baddr",    32'(wr_baddr),    e_wba);
        check("usb_req",     32'(usb_req),     e_ureq);
        check("usb_baddr",   32'(usb_baddr),   e_uba);
        check("ovf_cnt",     32'(ovf_cnt),     m_ovf);
        check("err_timeout", 32'(err_timeout), e_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(wr_gnt),      32'd0);
        check({tag, "_wba"},   32'(wr_baddr),    32'd0);
        check({tag, "_ureq"},  32'(usb_req),     32'd0);
        check({tag, "_uba"},   32'(usb_baddr),   32'd0);
        check({tag, "_ovf"},   32'(ovf_cnt),     32'd0);
        check({tag, "_err"},   32'(err_timeout), 32'd0);
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later, pulses cleared.
    task automatic step();
        @(posedge mclk);
        model_clock();
        #1;
        check_model();
        wr_eop = 2'b00; acq_start = 1'b0; usb_ack = 1'b0; usb_done = 1'b0;
    endtask

    task automatic serve_one(output logic [31:0] pg);
        int k;
        k = 0;
        while (usb_req !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        check("usb_req_wait", 32'(usb_req), 32'd1);
        pg = 32'(usb_baddr);
        usb_ack = 1'b1; step();
        step();
        usb_done = 1'b1; step();
    endtask

    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        wr_req = 2'b00; wr_eop = 2'b00; acq_start = 1'b0; usb_ack = 1'b0; usb_done = 1'b0;
        @(negedge mclk) rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pg;
        int errs;
        rst_n = 1'b1; wr_req = 2'b00; wr_eop = 2'b00;
        acq_start = 1'b0; usb_ack = 1'b0; usb_done = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #10 check_all_zero("reset");
        @(negedge mclk) rst_n = 1'b1;

        // Control round trip, including a zero-length refill.
        wr_req = 2'b01; step();
        check("ctrl_gnt", 32'(wr_gnt), 32'd1);
        check("ctrl_baddr", 32'(wr_baddr), 32'd0);
        wr_req = 2'b00;
        repeat (4) step();
        wr_eop = 2'b01; step();
        step();
        check("ctrl_usb_req", 32'(usb_req), 32'd1);
        check("ctrl_usb_baddr", 32'(usb_baddr), 32'd0);
        serve_one(pg); check("ctrl_sent", pg, 32'd0);
        wr_req = 2'b01; step();
        check("ctrl_regrant", 32'(wr_gnt), 32'd1);
        wr_req = 2'b00; wr_eop = 2'b01; step();
        serve_one(pg); check("ctrl_zero_len", pg, 32'd0);

        // Simultaneous requests: control first, data two cycles after control's eop.
        wr_req = 2'b11; step();
        check("sim_ctrl_first", 32'(wr_gnt), 32'd1);
        wr_req = 2'b10; wr_eop = 2'b01; step();
        check("sim_gap", 32'(wr_gnt), 32'd0);
        step();
        check("sim_data_gnt", 32'(wr_gnt), 32'd2);
        check("sim_data_page", 32'(wr_baddr), 32'd2);
        wr_req = 2'b00; wr_eop = 2'b10; step();
        serve_one(pg); check("sim_send0", pg, 32'd0);
        serve_one(pg); check("sim_send1", pg, 32'd2);

        // Ping-pong stall after an immediate acquisition restart.
        acq_start = 1'b1; step();
        wr_req = 2'b10; step();
        check("pp_gnt_a", 32'(wr_baddr), 32'd2);
        wr_req = 2'b00; wr_eop = 2'b10; step();
        wr_req = 2'b10; step();
        check("pp_gnt_b", 32'(wr_baddr), 32'd3);
        wr_req = 2'b00; wr_eop = 2'b10; step();
        repeat (3) step();
        wr_req = 2'b10;
        repeat (3) step();
        check("pp_stall_gnt", 32'(wr_gnt), 32'd0);
        check("pp_ovf", 32'(ovf_cnt), 32'd1);
        serve_one(pg); check("pp_order0", pg, 32'd2);
        step();
        check("pp_release_gnt", 32'(wr_gnt), 32'd2);
        check("pp_release_page", 32'(wr_baddr), 32'd2);
        wr_req = 2'b00; wr_eop = 2'b10; step();
        serve_one(pg); check("pp_order1", pg, 32'd3);
        serve_one(pg); check("pp_order2", pg, 32'd2);

        // Deferred acq_start: while page 3 sends, then while a data fill is open.
        wr_req = 2'b10; step();
        check("acq_fill3", 32'(wr_baddr), 32'd3);
        wr_req = 2'b00; wr_eop = 2'b10; step();
        repeat (2) step();
        acq_start = 1'b1; step();
        serve_one(pg); check("acq_send3", pg, 32'd3);
        wr_req = 2'b10; step();
        check("acq_after_send", 32'(wr_baddr), 32'd2);
        acq_start = 1'b1; wr_req = 2'b00; step();
        wr_eop = 2'b10; step();
        serve_one(pg); check("acq_send2", pg, 32'd2);
        wr_req = 2'b10; step();
        check("acq_in_fill", 32'(wr_baddr), 32'd2);
        wr_req = 2'b00; wr_eop = 2'b10; step();
        serve_one(pg); check("acq_send2b", pg, 32'd2);

`ifdef TX_SCHED_TIMEOUT_EN
        acq_start = 1'b1; step();
        wr_req = 2'b10; step();
        check("tmo_gnt", 32'(wr_baddr), 32'd2);
        wr_req = 2'b00;
        errs = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (err_timeout === 1'b1) errs++;
        end
        check("tmo_pulses", errs, 32'd1);
        check("tmo_gnt_drop", 32'(wr_gnt), 32'd0);
        wr_req = 2'b10; step();
        check("tmo_regrant", 32'(wr_baddr), 32'd2);
        wr_req = 2'b00; wr_eop = 2'b10; step();
        serve_one(pg); check("tmo_send", pg, 32'd2);
`endif

        // Asynchronous reset with a request pending and a writer granted.
        wr_req = 2'b01; step();
        wr_req = 2'b00; wr_eop = 2'b01; step();
        wr_req = 2'b10; step();
        step();
        check("rst_pre_req", 32'(usb_req), 32'd1);
        check("rst_pre_gnt", 32'(wr_gnt), 32'd2);
        mid_reset("rst_mid");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (wr_gnt[b] === 1'b1) begin
                    if ($urandom_range(1) == 0) wr_req[b] = 1'b0;
                    if ($urandom_range(5) == 0) wr_eop[b] = 1'b1;
                end else if ($urandom_range(7) == 0) begin
                    wr_req[b] = ~wr_req[b];
                end
                if ($urandom_range(29) == 0) wr_eop[b] = 1'b1;
            end
            acq_start = ($urandom_range(39) == 0);
            usb_ack   = ($urandom_range(2) == 0);
            usb_done  = ($urandom_range(3) == 0);
            step();
            if (i == 1500) mid_reset("rst_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_page_sched.md
# tx_page_sched

Scheduler for the four-page USB TX buffer between the command decoder and the USB transmit engine. It grants the single buffer write port to one of two producers: control responses on page 0, and ADC data on pages 2/3 ping-pong. It tracks each page's fill/send state and hands filled pages to the USB engine in a fixed priority order. Page 1 stays reserved.

## Interface
- `TIMEOUT_CYC`, default 1024: maximum cycles a granted writer may hold a page before it is aborted.
- `OVF_NBIT`, default 8: width of the data-overflow counter.
- `mclk` in 1: main clock, 48 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_req` in 2: write requests; bit0 is control, bit1 is ADC data. Level, held until granted.
- `wr_eop` in 2: one-cycle pulse from the granted writer when its page is complete.
- `wr_gnt` out 2: one-hot grant, held until the writer's eop.
- `wr_baddr` out `BUFFER_BADDR_NBIT`: page base address for the granted writer.
- `acq_start` in 1: one-cycle pulse; new acquisition, restart the ping-pong at page 2.
- `usb_req` out 1: page ready to send.
- `usb_baddr` out `BUFFER_BADDR_NBIT`: page to send, valid while `usb_req`.
- `usb_ack` in 1: one-cycle pulse; the engine has accepted the request.
- `usb_done` in 1: one-cycle pulse; the page has been fully transmitted.
- `ovf_cnt` out `OVF_NBIT`: saturating count of stalled data requests.
- `err_timeout` out 1: one-cycle pulse when a page is aborted by timeout.

## Operation
- **Page states:** each of pages 0, 2 and 3 is in one of FREE, FILL, READY or SEND.
- **Write FSM states:** W_IDLE, W_CTRL, W_DATA.
- **W_IDLE arbitration:**
  - If `wr_req[0]` is set and page 0 is FREE, grant control: page 0 → FILL, go to W_CTRL.
  - Otherwise, if `wr_req[1]` is set and page `wr_ptr` is FREE, grant data: page `wr_ptr` → FILL, go to W_DATA.
  - Control has fixed priority over data.
- **W_CTRL / W_DATA:** on `wr_eop` for the granted bit, the page → READY and the FSM returns to W_IDLE. For data, `wr_ptr` also toggles 2↔3. `wr_eop` on a non-granted bit is ignored.
- **Strict alternation:** data is never granted the other data page when `wr_ptr`'s page is busy; the requester waits.
- **Overflow:** `ovf_cnt` increments when `wr_req[1]` rises while page `wr_ptr` is not FREE. It saturates at all-ones and is cleared only by reset.
- **Send FSM states:** S_IDLE, S_REQ, S_BUSY.
- **S_IDLE:**
  - If page 0 is READY, select page 0.
  - Else, if page `tx_ptr` is READY, select `tx_ptr`.
  - On selection the page → SEND and the FSM goes to S_REQ.
- **S_REQ:** hold `usb_req` high until `usb_ack`, then go to S_BUSY.
- **S_BUSY:** on `usb_done` the page → FREE. For a data page `tx_ptr` toggles. Return to S_IDLE.
- **acq_start:**
  - Applied immediately when pages 2 and 3 are both FREE and the write FSM is not in W_DATA: `wr_ptr` = `tx_ptr` = 2.
  - Otherwise it is latched as pending and applied on the first cycle that condition holds.
  - A second pulse while pending is absorbed.
- **Timeout:** with the feature compiled in (see Configuration), a cycle counter runs in W_CTRL/W_DATA. When it reaches `TIMEOUT_CYC` with no eop:
  - the page → FREE and `wr_ptr` is not toggled;
  - the grant drops and the FSM goes to W_IDLE;
  - `err_timeout` pulses.
- **Reset:** mid-operation or otherwise, all pages → FREE and both FSMs → idle.

## Timing
- **Reset values:** `wr_gnt`=0, `wr_baddr`=0, `usb_req`=0, `usb_baddr`=0, `ovf_cnt`=0, `err_timeout`=0; internally `wr_ptr`=`tx_ptr`=2, pending `acq_start` cleared.
- **All outputs are registered.**
- **Grant latency:** `wr_req` sampled high in cycle N with the target page FREE gives `wr_gnt` and `wr_baddr` valid in cycle N+1.
- **Eop:** `wr_eop` in cycle M drops `wr_gnt` in M+1. The next grant is earliest M+2.
- **Send latency:** a page becoming READY in cycle K raises `usb_req` in K+1 if the send FSM is in S_IDLE. `usb_ack` in the same cycle `usb_req` rises is valid.
- **Page release:** `usb_done` in cycle D makes the page FREE in D+1. A waiting writer for that page is granted in D+2.
- **Simultaneous events:**
  - `wr_eop` and `usb_done` in the same cycle are both applied.
  - `usb_ack` outside S_REQ and `usb_done` outside S_BUSY are ignored.
- **Zero-length fill:** `wr_eop` in the grant cycle N+1 is legal.

## Configuration
- **`TX_SCHED_TIMEOUT_EN` defined:** the timeout counter is present and behaves as in Operation. `err_timeout` pulses on abort.
- **Not defined:** there is no counter and a granted writer may hold its page indefinitely. `err_timeout` is tied to 0.

## Test plan
- **Control round trip:** `wr_req`=01 at cycle 0 → `wr_gnt`=01 and `wr_baddr`=0 at cycle 1. `wr_eop`=01 at cycle 5 → `usb_req`=1 with `usb_baddr`=0 at cycle 7. `usb_ack`, then `usb_done` → page 0 grantable again.
- **Simultaneous requests:** `wr_req`=11 → control granted first. Data granted page 2 two cycles after control's eop.
- **Ping-pong stall:**
  - Fill pages 2 and 3 with `usb_ack` withheld, then raise `wr_req[1]` → no grant and `ovf_cnt`=1.
  - After `usb_done` for page 2 → grant to page 2.
  - Send order is 2, 3, 2.
- **Deferred acq_start:** pulse `acq_start` while page 3 is in SEND → pointer reset deferred. After `usb_done`, the next data grant is page 2.
- **Timeout (`TX_SCHED_TIMEOUT_EN`, `TIMEOUT_CYC`=16):** grant data with no eop → `err_timeout` pulses once and page 2 returns to FREE. The following data grant is page 2 again.
- **Reset:** assert `rst_n`=0 with `usb_req` high and a writer granted → all outputs return to 0 asynchronously.
